// File: rtl/smachine_pkg.sv
// S-Machine shared types: opcodes, FSM states and instruction field positions.
// Imported by the interpreter top and its ALU.
package smachine_pkg;

   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int RSEL_BIT = 11;
   localparam int IMM_BIT  = 10;
   localparam int K_MSB    = 7;
   localparam int K_LSB    = 0;

   typedef enum logic [3:0] {
      OP_LD  = 4'd0,
      OP_ST  = 4'd1,
      OP_INC = 4'd2,
      OP_DEC = 4'd3,
      OP_ADD = 4'd4,
      OP_SUB = 4'd5,
      OP_OR  = 4'd6,
      OP_AND = 4'd7,
      OP_XOR = 4'd8,
      OP_JMP = 4'd9,
      OP_JZ  = 4'd10
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MEM,
      S_DONE
   } state_t;

endpackage

// File: rtl/inst_interpreter_if.sv
// Sequencer + data-memory bundle of the S-Machine interpreter.
// slave is the interpreter side; master is sequencer/memory side.
interface inst_interpreter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              start;
   logic [DATA_W-1:0] inst;
   logic              done;
   logic [ADDR_W-1:0] PC;
   logic [DATA_W-1:0] data_in_memory;
   logic              read_write_memory;
   logic [DATA_W-1:0] data_out_memory;
   logic [ADDR_W-1:0] addr;

   modport master (
      output start, inst, data_in_memory,
      input  done, PC, read_write_memory,
      input  data_out_memory, addr
   );

   modport slave (
      input  start, inst, data_in_memory,
      output done, PC, read_write_memory,
      output data_out_memory, addr
   );
endinterface

// File: rtl/smachine_alu.sv
// Combinational register-op ALU; modulo-2^W, no flags.
// Non-ALU opcodes pass Rd through unchanged.
module smachine_alu
   import smachine_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [3:0]   op,
   input  logic [W-1:0] rd,
   input  logic [W-1:0] rs,
   output logic [W-1:0] result
);

   always_comb begin
      result = rd;
      unique case (op)
         OP_INC:  result = rd + 1'b1;
         OP_DEC:  result = rd - 1'b1;
         OP_ADD:  result = rd + rs;
         OP_SUB:  result = rd - rs;
         OP_OR:   result = rd | rs;
         OP_AND:  result = rd & rs;
         OP_XOR:  result = rd ^ rs;
         default: result = rd;
      endcase
   end

endmodule

// File: rtl/inst_interpreter.sv
// S-Machine instruction interpreter: IDLE -> EXEC -> [MEM] -> DONE.
// Owns registers A/B, the PC and the data-memory strobes.
module inst_interpreter
   import smachine_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input logic               clk,
   input logic               reset,
   inst_interpreter_if.slave bus
);

   state_t            state, state_n;
   logic [DATA_W-1:0] inst_q, inst_n;
   logic [DATA_W-1:0] a, a_n, b, b_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [DATA_W-1:0] dout, dout_n;
   logic              rw, rw_n;

   logic [3:0]        op;
   logic              rsel, imm;
   logic [ADDR_W-1:0] k;
   logic [DATA_W-1:0] rd, rs, alu_res;
   logic              wr_en;
   logic [DATA_W-1:0] wr_val;

   assign op   = inst_q[OP_MSB:OP_LSB];
   assign rsel = inst_q[RSEL_BIT];
   assign imm  = inst_q[IMM_BIT];
   assign k    = inst_q[K_MSB:K_LSB];
   assign rd   = rsel ? b : a;
   assign rs   = rsel ? a : b;

   smachine_alu #(.W(DATA_W)) u_alu (
      .op     (op),
      .rd     (rd),
      .rs     (rs),
      .result (alu_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         inst_q <= '0;
         a      <= '0;
         b      <= '0;
         pc     <= '0;
         addr   <= '0;
         dout   <= '0;
         rw     <= 1'b0;
      end else begin
         state  <= state_n;
         inst_q <= inst_n;
         a      <= a_n;
         b      <= b_n;
         pc     <= pc_n;
         addr   <= addr_n;
         dout   <= dout_n;
         rw     <= rw_n;
      end
   end

   always_comb begin
      state_n = state;
      inst_n  = inst_q;
      a_n     = a;
      b_n     = b;
      pc_n    = pc;
      addr_n  = addr;
      dout_n  = dout;
      rw_n    = 1'b0;
      wr_en   = 1'b0;
      wr_val  = alu_res;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               inst_n  = bus.inst;
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            state_n = S_DONE;
            pc_n    = pc + 1'b1;
            case (op)
               OP_LD: begin
                  if (imm) begin
                     wr_en  = 1'b1;
                     wr_val = {{(DATA_W-ADDR_W){1'b0}}, k};
                  end else begin
                     // PC advances when the read data lands in MEM
                     addr_n  = k;
                     pc_n    = pc;
                     state_n = S_MEM;
                  end
               end
               OP_ST: begin
                  addr_n = k;
                  dout_n = rd;
                  rw_n   = 1'b1;
               end
               OP_INC, OP_DEC, OP_ADD, OP_SUB,
               OP_OR, OP_AND, OP_XOR: begin
                  wr_en = 1'b1;
               end
               OP_JMP: pc_n = k;
               OP_JZ: begin
                  if (rd == '0) pc_n = k;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            wr_en   = 1'b1;
            wr_val  = bus.data_in_memory;
            pc_n    = pc + 1'b1;
            state_n = S_DONE;
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (wr_en) begin
         if (rsel) b_n = wr_val;
         else      a_n = wr_val;
      end
   end

   assign bus.done              = (state == S_DONE);
   assign bus.PC                = pc;
   assign bus.addr              = addr;
   assign bus.data_out_memory   = dout;
   assign bus.read_write_memory = rw;

endmodule

// File: tb/tb_inst_interpreter.sv
// Directed bench for inst_interpreter with a 256x16 memory model.
// Expected values are hand-computed per instruction sequence.
module tb_inst_interpreter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   inst_interpreter_if bus ();

   inst_interpreter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] mem [256];
   assign bus.data_in_memory = mem[bus.addr];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[8'h20] <= 16'hBEEF;
         mem[8'h21] <= 16'hFFFF;
      end else if (bus.read_write_memory) begin
         mem[bus.addr] <= bus.data_out_memory;
      end
   end

   int tests = 0;
   int fails = 0;
   logic        seen_rw;
   logic [7:0]  seen_addr;
   logic [15:0] seen_dout;
   int          ndone;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input logic [15:0] i, input int lat);
      int n;
      @(negedge clk);
      bus.start = 1'b1;
      bus.inst  = i;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      seen_rw   = bus.read_write_memory;
      seen_addr = bus.addr;
      seen_dout = bus.data_out_memory;
      check("latency", n, lat);
      @(posedge clk); #1;
      check("rw_off", bus.read_write_memory, 1'b0);
   endtask

   task automatic count_done(input int cycles);
      ndone = 0;
      for (int c = 0; c < cycles; c++) begin
         if (bus.done) ndone++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.inst  = 16'h0000;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_pc", bus.PC, 8'h00);
      check("rst_done", bus.done, 1'b0);
      check("rst_rw", bus.read_write_memory, 1'b0);
      check("rst_addr", bus.addr, 8'h00);
      check("rst_dout", bus.data_out_memory, 16'h0000);

      // A:1 B:1, A:2, A:1, B:2, A:3, A:2, A:0
      run(16'h0401, 1);
      run(16'h0C01, 1);
      run(16'h4000, 1);
      run(16'h5000, 1);
      run(16'h2801, 1);
      run(16'h6000, 1);
      run(16'h7000, 1);
      run(16'h8000, 1);
      check("pc_alu", bus.PC, 8'd8);

      run(16'h1010, 1);
      check("stA_rw", seen_rw, 1'b1);
      check("stA_addr", seen_addr, 8'h10);
      check("stA_data", seen_dout, 16'h0000);
      run(16'h1810, 1);
      check("stB_data", seen_dout, 16'h0002);
      check("stB_mem", mem[8'h10], 16'h0002);

      run(16'h0020, 2);
      run(16'h1011, 1);
      check("ldd_data", seen_dout, 16'hBEEF);
      check("ldd_mem", mem[8'h11], 16'hBEEF);
      check("pc_ldd", bus.PC, 8'd12);

      run(16'h0021, 2);
      run(16'h2000, 1);
      run(16'h1012, 1);
      check("inc_wrap", seen_dout, 16'h0000);
      run(16'h3000, 1);
      run(16'h1013, 1);
      check("dec_wrap", seen_dout, 16'hFFFF);
      check("pc_wrap", bus.PC, 8'd17);
      run(16'h2000, 1);

      run(16'hA040, 1);
      check("jz_taken", bus.PC, 8'h40);
      run(16'hA850, 1);
      check("jz_not", bus.PC, 8'h41);
      run(16'h90FF, 1);
      check("jmp", bus.PC, 8'hFF);
      run(16'hB000, 1);
      check("pc_ovf", bus.PC, 8'h00);
      check("addr_hold", bus.addr, 8'h13);

      @(negedge clk);
      bus.start = 1'b1;
      bus.inst  = 16'h2801;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      count_done(6);
      check("exec_start", ndone, 1);
      check("pc_exec", bus.PC, 8'h01);

      @(negedge clk);
      bus.start = 1'b1;
      bus.inst  = 16'h0820;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      count_done(6);
      check("mem_start", ndone, 1);
      run(16'h1814, 1);
      check("ldB_data", seen_dout, 16'hBEEF);
      check("pc_mem", bus.PC, 8'h03);

      @(negedge clk);
      bus.start = 1'b1;
      bus.inst  = 16'h0821;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mrst_pc", bus.PC, 8'h00);
      check("mrst_done", bus.done, 1'b0);
      check("mrst_rw", bus.read_write_memory, 1'b0);
      check("mrst_addr", bus.addr, 8'h00);
      count_done(5);
      check("mrst_nodone", ndone, 0);
      run(16'h1815, 1);
      check("mrst_noupd", seen_dout, 16'h0000);
      check("mrst_pc1", bus.PC, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
